ili9341_frame_scheduler: RTL
============================

# ili9341_frame_scheduler

Frame-level scheduler and arbiter for the ILI9341 pixel stream. Several image sources (mood/state requesters) share one pixel stream, and this block picks which one owns it. Grants change only on frame boundaries, and each grant is held for a minimum number of frames. The block drives the solid-colour pixel stream and the end-of-frame pulse that feed the `ili9341_controller` input side, clocked by the controller's data clock.

## Interface
- `RESOLUTION`, 320*240, pixels per frame.
- `PIXEL_SIZE`, 16, RGB565 pixel width.
- `NUM_REQ`, 4, number of requesters (2..8).
- `MIN_DWELL_FRAMES`, 2, minimum consecutive frames per grant (≥1).
- `clk_input_data`  in  1  pixel clock from the controller; one pixel consumed per rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req`  in  NUM_REQ  level requests, one per source.
- `req_color`  in  NUM_REQ*PIXEL_SIZE  per-source colour; source i occupies bits [i*PIXEL_SIZE +: PIXEL_SIZE].
- `grant`  out  NUM_REQ  one-hot owner of the current or last frame; 0 when idle.
- `current_pixel`  out  PIXEL_SIZE  pixel data to the controller.
- `pixel_valid`  out  1  high while `current_pixel` is a frame pixel.
- `frame_done`  out  1  one-cycle pulse at the end of each frame; connects to the controller's `frame_done`.
- `frame_count`  out  8  completed frames; wraps 255→0.

## Operation
- States: IDLE, STREAM, FRAME_END.
- All outputs are registered.
- IDLE:
  - `pixel_valid`=0, `current_pixel`=0, `grant`=0.
  - If any `req` bit is high, arbitrate, latch the winner's colour and go to STREAM.
- STREAM:
  - `pixel_valid`=1 and `current_pixel`=latched colour.
  - Pixel counter (clog2(RESOLUTION) bits) increments once per cycle.
  - At count RESOLUTION-1, go to FRAME_END.
- FRAME_END (one cycle):
  - `frame_done`=1, `pixel_valid`=0, `current_pixel`=0.
  - Counter clears, `frame_count`+1, dwell counter +1.
  - Then decide the next owner:
    - Owner's `req` high and dwell < MIN_DWELL_FRAMES: keep the owner and reload its current colour.
    - Otherwise: dwell clears and round-robin arbitration runs, starting at the index after the owner.
    - If the owner is the only requester, it keeps the grant.
    - No requester at all: go to IDLE.
    - Any winner: go to STREAM.
- Round-robin pointer: after reset, index 0 has highest priority. The pointer advances to winner+1 (mod NUM_REQ) on every new grant.
- Colour and grant are frozen for a whole frame. Changes to `req` or `req_color` mid-frame take effect only at FRAME_END.
- If the owner drops `req` mid-frame, the frame still completes with the owner's colour.

## Timing
- Reset values: state IDLE, `grant`=0, `current_pixel`=0, `pixel_valid`=0, `frame_done`=0, `frame_count`=0, counters 0, RR pointer 0.
- Reset has priority over every other event, including mid-frame; no partial `frame_done` is produced.
- Start latency: `req` sampled high at edge t in IDLE gives the first valid pixel at edge t+1.
- Frame period: RESOLUTION valid cycles plus one FRAME_END cycle, i.e. RESOLUTION+1 cycles.
- Back-to-back frames have no extra gap.
- `grant` updates on the same edge that enters STREAM and holds until the next FRAME_END decision. On entry to IDLE, `grant` clears.
- All `req` bits low for the whole of IDLE: no frames and no `frame_done` are produced (without the macro).

## Configuration
- Macro: `FRAME_SCHED_BLANK_EN`.
- Defined:
  - IDLE is replaced by blank frames: full RESOLUTION frames of 16'h001F with `pixel_valid`=1, `grant`=0, and normal `frame_done` and `frame_count`.
  - A request arriving mid-blank-frame is granted at that frame's FRAME_END.
- Undefined: IDLE is silent, as described in Operation.

## Test plan
- RESOLUTION=8, reset then `req`=4'b0001, `req_color[15:0]`=16'hFFE0:
  - 8 cycles of `pixel_valid`=1 with 16'hFFE0, then `frame_done`=1 for one cycle.
  - `frame_count`=1; `grant`=4'b0001 throughout.
- `req`=4'b0011, MIN_DWELL_FRAMES=2: grant sequence by frame is 0001, 0001, 0010, 0010, 0001.
- Owner drops `req` at pixel 3 of its first frame, `req`=4'b0100 pending:
  - The frame finishes in the old colour.
  - The next frame is granted to 0100 despite dwell not being met.
- `req_color` changed mid-frame: the new value appears only from the first pixel after `frame_done`.
- `rst`=0 at pixel 5:
  - Next edge gives all outputs 0 and no `frame_done`.
  - After release with `req` high, the first pixel arrives one cycle later.
- `FRAME_SCHED_BLANK_EN` with `req`=0:
  - Continuous 9-cycle frames of 16'h001F, `grant`=0.
  - `frame_count` wraps 255→0 after 256 frames.

Source files
------------

// File: rtl/ili9341_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ili9341_frame_scheduler
// Purpose  : Frame-level round-robin arbiter for the ILI9341 pixel stream.
//            Grants change only on frame boundaries and are held for at least
//            MIN_DWELL_FRAMES frames. Emits a solid-colour pixel stream and an
//            end-of-frame pulse on the controller's data clock.
// Options  : FRAME_SCHED_BLANK_EN - when defined, idle time is filled with
//            blank (16'h001F) frames instead of a silent stream.
// Revision : 1.0 - initial release
// ============================================================================
module ili9341_frame_scheduler #(
  parameter int RESOLUTION       = 320*240,
  parameter int PIXEL_SIZE       = 16,
  parameter int NUM_REQ          = 4,
  parameter int MIN_DWELL_FRAMES = 2
) (
  input  logic                          clk_input_data,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*PIXEL_SIZE-1:0] req_color,
  output logic [NUM_REQ-1:0]            grant,
  output logic [PIXEL_SIZE-1:0]         current_pixel,
  output logic                          pixel_valid,
  output logic                          frame_done,
  output logic [7:0]                    frame_count
);

  localparam int c_cnt_w = $clog2(RESOLUTION);
  localparam int c_idx_w = $clog2(NUM_REQ);
  localparam int c_dw_w  = $clog2(MIN_DWELL_FRAMES + 1);

  localparam logic [c_cnt_w-1:0]    c_last_pix  = c_cnt_w'(RESOLUTION - 1);
  localparam logic [c_idx_w-1:0]    c_last_idx  = c_idx_w'(NUM_REQ - 1);
  localparam logic [c_idx_w:0]      c_num_req   = (c_idx_w + 1)'(NUM_REQ);
  localparam logic [c_dw_w-1:0]     c_min_dwell = c_dw_w'(MIN_DWELL_FRAMES);
  localparam logic [PIXEL_SIZE-1:0] c_blank     = PIXEL_SIZE'(16'h001F);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAM    = 2'd1,
    ST_FRAME_END = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_cnt_w-1:0]      r_pix_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]      r_grant, w_grant_nxt;
  logic [c_idx_w-1:0]      r_owner, w_owner_nxt;
  logic [c_idx_w-1:0]      r_rr_ptr, w_ptr_nxt;
  logic [c_dw_w-1:0]       r_dwell, w_dwell_nxt;
  logic [PIXEL_SIZE-1:0]   r_pixel, w_pixel_nxt;
  logic                    r_valid, w_valid_nxt;
  logic                    r_done, w_done_nxt;
  logic [7:0]              r_frame_count, w_fcnt_nxt;

  logic [2*NUM_REQ-1:0]    w_req_dbl;
  logic [NUM_REQ-1:0]      w_req_rot;
  logic [c_idx_w-1:0]      w_rot_sel;
  logic [c_idx_w:0]        w_arb_sum;
  logic [c_idx_w-1:0]      w_arb_idx;
  logic [c_idx_w-1:0]      w_ptr_after;
  logic [PIXEL_SIZE-1:0]   w_win_color;
  logic [PIXEL_SIZE-1:0]   w_own_color;
  logic                    w_any;
  logic                    w_keep;
  logic                    w_new_grant;
  logic                    w_go_idle;

  // Round-robin pick: rotate requests so the pointer sits at bit 0, take the lowest set bit
  always_comb begin
    w_req_dbl = {req, req};
    w_req_rot = w_req_dbl[r_rr_ptr +: NUM_REQ];
    w_rot_sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_rot_sel = c_idx_w'(i);
    end
    w_arb_sum   = {1'b0, r_rr_ptr} + {1'b0, w_rot_sel};
    w_arb_idx   = (w_arb_sum >= c_num_req) ? c_idx_w'(w_arb_sum - c_num_req)
                                           : w_arb_sum[c_idx_w-1:0];
    w_ptr_after = (w_arb_idx == c_last_idx) ? '0 : w_arb_idx + 1'b1;
    w_win_color = req_color[w_arb_idx*PIXEL_SIZE +: PIXEL_SIZE];
    w_own_color = req_color[r_owner*PIXEL_SIZE +: PIXEL_SIZE];
    w_any       = |req;
    w_keep      = (|(req & r_grant)) && (r_dwell < c_min_dwell);
  end

  // Next-state and next-output decode; all outputs are registered from these values
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_pix_cnt;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_rr_ptr;
    w_dwell_nxt = r_dwell;
    w_pixel_nxt = r_pixel;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_fcnt_nxt  = r_frame_count;
    w_new_grant = 1'b0;
    w_go_idle   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any) w_new_grant = 1'b1;
        else       w_go_idle   = 1'b1;
      end
      ST_STREAM: begin
        if (r_pix_cnt == c_last_pix) begin
          w_state_nxt = ST_FRAME_END;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_valid_nxt = 1'b0;
          w_pixel_nxt = '0;
          w_fcnt_nxt  = r_frame_count + 8'd1;
          // Blank frames have no owner, so they never accumulate dwell
          if (|r_grant) w_dwell_nxt = r_dwell + 1'b1;
        end else begin
          w_cnt_nxt = r_pix_cnt + 1'b1;
        end
      end
      ST_FRAME_END: begin
        if (w_keep) begin
          w_state_nxt = ST_STREAM;
          w_pixel_nxt = w_own_color;
          w_valid_nxt = 1'b1;
        end else if (w_any) begin
          w_new_grant = 1'b1;
        end else begin
          w_go_idle = 1'b1;
        end
      end
      default: w_go_idle = 1'b1;
    endcase

    if (w_new_grant) begin
      w_state_nxt = ST_STREAM;
      w_cnt_nxt   = '0;
      w_grant_nxt = NUM_REQ'(1) << w_arb_idx;
      w_owner_nxt = w_arb_idx;
      w_ptr_nxt   = w_ptr_after;
      w_dwell_nxt = '0;
      w_pixel_nxt = w_win_color;
      w_valid_nxt = 1'b1;
    end

    if (w_go_idle) begin
`ifdef FRAME_SCHED_BLANK_EN
      w_state_nxt = ST_STREAM;
      w_pixel_nxt = c_blank;
      w_valid_nxt = 1'b1;
`else
      w_state_nxt = ST_IDLE;
      w_pixel_nxt = '0;
      w_valid_nxt = 1'b0;
`endif
      w_grant_nxt = '0;
      w_cnt_nxt   = '0;
      w_dwell_nxt = '0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_input_data) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_pix_cnt     <= '0;
      r_grant       <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_dwell       <= '0;
      r_pixel       <= '0;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pix_cnt     <= w_cnt_nxt;
      r_grant       <= w_grant_nxt;
      r_owner       <= w_owner_nxt;
      r_rr_ptr      <= w_ptr_nxt;
      r_dwell       <= w_dwell_nxt;
      r_pixel       <= w_pixel_nxt;
      r_valid       <= w_valid_nxt;
      r_done        <= w_done_nxt;
      r_frame_count <= w_fcnt_nxt;
    end
  end

  assign grant         = r_grant;
  assign current_pixel = r_pixel;
  assign pixel_valid   = r_valid;
  assign frame_done    = r_done;
  assign frame_count   = r_frame_count;

endmodule
`default_nettype wire
